// File: rtl/fetch_issue_ctrl.sv
// Instruction fetch/issue sequencer: fetches a word at PC, issues it to the decoder, waits for execution.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN (limit set by TIMEOUT_CYC).
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | stopped; leaves when halt=0
// FETCH     | mem_req held at PC until mem_ack (or watchdog)
// ISSUE     | one-cycle instr_valid strobe, PC advances
// WAIT_EXEC | waiting for exec_done, optional branch redirect
module fetch_issue_ctrl #(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_data,
  output logic [31:0]     instr_out,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic            branch_en,
  input  logic [PC_W-1:0] branch_target,
  output logic            busy,
  output logic            fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT_EXEC} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_out_q, instr_out_d;
  logic            mem_req_q, mem_req_d;
  logic            instr_valid_q, instr_valid_d;
  logic            busy_q, busy_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             fetch_err_q, fetch_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_out_d = instr_out_q;
`ifdef FETCH_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    fetch_err_d = fetch_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!halt) state_d = FETCH;
      end
      FETCH: begin
        if (mem_ack) begin
          instr_out_d = mem_data;
          state_d     = ISSUE;
        end
`ifdef FETCH_TIMEOUT_EN
        // Down-counter reaches terminal count on the TIMEOUT_CYC-th FETCH cycle.
        else if (tmo_cnt_q == '0) begin
          fetch_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
        end
`endif
      end
      ISSUE: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = (instr_out_q[7:0] == 8'hFF) ? FETCH : WAIT_EXEC;
      end
      WAIT_EXEC: begin
        if (exec_done) begin
          if (branch_en) pc_d = branch_target;
          state_d = halt ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef FETCH_TIMEOUT_EN
    if (state_d == FETCH && state_q != FETCH) tmo_cnt_d = TMO_W'(TIMEOUT_CYC - 1);
`endif

    // Outputs are registered images of the next state.
    mem_req_d     = (state_d == FETCH);
    instr_valid_d = (state_d == ISSUE);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_out_q   <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      fetch_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_out_q   <= instr_out_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      fetch_err_q   <= fetch_err_d;
`endif
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign instr_out   = instr_out_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err   = fetch_err_q;
`else
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed bench for fetch_issue_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_fetch_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, halt, mem_req, mem_ack, instr_valid, exec_done, branch_en, busy, fetch_err;
  logic [15:0] mem_addr, branch_target;
  logic [31:0] mem_data, instr_out;
  int          checks = 0;
  int          failures = 0;

  fetch_issue_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst), .halt(halt), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .instr_out(instr_out),
    .instr_valid(instr_valid), .exec_done(exec_done), .branch_en(branch_en),
    .branch_target(branch_target), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_time_limit: bench did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; halt = 1'b1; mem_ack = 1'b0; mem_data = '0;
    exec_done = 1'b0; branch_en = 1'b0; branch_target = '0;
    cyc(); cyc();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_fetch_err got=%b exp=0", fetch_err); end
    checks++; if (instr_out !== 32'h0) begin failures++; $display("FAIL reset_instr_out got=%h exp=0", instr_out); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
  endtask

  task automatic test_fetch_issue();
    rst = 1'b1; halt = 1'b0;
    cyc();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL fetch_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL fetch_addr got=%h exp=0000", mem_addr); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fetch_busy got=%b exp=1", busy); end
    cyc();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL fetch_req_hold got=%b exp=1", mem_req); end
    mem_ack = 1'b1; mem_data = 32'h00000103;
    cyc();
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL issue_valid got=%b exp=1", instr_valid); end
    checks++; if (instr_out !== 32'h00000103) begin failures++; $display("FAIL issue_instr got=%h exp=00000103", instr_out); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL issue_req_drop got=%b exp=0", mem_req); end
    cyc();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL issue_single_cycle got=%b exp=0", instr_valid); end
    checks++; if (mem_addr !== 16'h0001) begin failures++; $display("FAIL pc_inc got=%h exp=0001", mem_addr); end
    checks++; if (busy !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL wait_exec busy=%b req=%b exp busy=1 req=0", busy, mem_req); end
    mem_ack = 1'b1; mem_data = 32'hDEAD0000;
    cyc();
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || instr_out !== 32'h00000103) begin failures++; $display("FAIL wait_ignores_ack req=%b instr=%h exp req=0 instr=00000103", mem_req, instr_out); end
  endtask

  task automatic test_branch();
    exec_done = 1'b1; branch_en = 1'b1; branch_target = 16'h0040;
    cyc();
    exec_done = 1'b0; branch_en = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin failures++; $display("FAIL branch req=%b addr=%h exp req=1 addr=0040", mem_req, mem_addr); end
  endtask

  task automatic test_nop();
    mem_ack = 1'b1; mem_data = 32'h000000FF;
    cyc();
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h000000FF) begin failures++; $display("FAIL nop_issue valid=%b instr=%h exp valid=1 instr=000000ff", instr_valid, instr_out); end
    cyc();
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0041) begin failures++; $display("FAIL nop_refetch valid=%b req=%b addr=%h exp 0 1 0041", instr_valid, mem_req, mem_addr); end
  endtask

  task automatic test_no_branch();
    mem_ack = 1'b1; mem_data = 32'h00000013;
    cyc();
    mem_ack = 1'b0;
    cyc();
    branch_en = 1'b1; branch_target = 16'h0099;
    cyc();
    branch_en = 1'b0;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0042) begin failures++; $display("FAIL branch_without_done req=%b addr=%h exp req=0 addr=0042", mem_req, mem_addr); end
    exec_done = 1'b1;
    cyc();
    exec_done = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0042) begin failures++; $display("FAIL done_no_branch req=%b addr=%h exp req=1 addr=0042", mem_req, mem_addr); end
  endtask

  task automatic test_wrap();
    mem_ack = 1'b1; mem_data = 32'h00000013;
    cyc();
    mem_ack = 1'b0;
    cyc();
    exec_done = 1'b1; branch_en = 1'b1; branch_target = 16'hFFFF;
    cyc();
    exec_done = 1'b0; branch_en = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_setup req=%b addr=%h exp req=1 addr=ffff", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = 32'h00000013;
    cyc();
    mem_ack = 1'b0;
    cyc();
    checks++; if (mem_addr !== 16'h0000 || busy !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL pc_wrap addr=%h busy=%b req=%b exp 0000 1 0", mem_addr, busy, mem_req); end
  endtask

  task automatic test_halt();
    exec_done = 1'b1;
    cyc();
    exec_done = 1'b0;
    halt = 1'b1;
    cyc(); cyc();
    checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL halt_in_fetch req=%b busy=%b exp 1 1", mem_req, busy); end
    mem_ack = 1'b1; mem_data = 32'h00000213;
    cyc();
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h00000213) begin failures++; $display("FAIL halt_issue valid=%b instr=%h exp 1 00000213", instr_valid, instr_out); end
    cyc();
    exec_done = 1'b1;
    cyc();
    exec_done = 1'b0;
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 16'h0001) begin failures++; $display("FAIL halt_idle busy=%b req=%b addr=%h exp 0 0 0001", busy, mem_req, mem_addr); end
    cyc();
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL halt_stay_idle busy=%b req=%b exp 0 0", busy, mem_req); end
  endtask

  task automatic test_reset_mid_fetch();
    halt = 1'b0;
    cyc();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin failures++; $display("FAIL resume_fetch req=%b addr=%h exp 1 0001", mem_req, mem_addr); end
    rst = 1'b0; mem_ack = 1'b1; mem_data = 32'h00000055;
    cyc();
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_fetch req=%b busy=%b valid=%b exp 0 0 0", mem_req, busy, instr_valid); end
    checks++; if (mem_addr !== 16'h0000 || instr_out !== 32'h0) begin failures++; $display("FAIL rst_mid_fetch_regs addr=%h instr=%h exp 0000 0", mem_addr, instr_out); end
    rst = 1'b1; halt = 1'b1;
    cyc();
    mem_ack = 1'b0;
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 32'h0) begin failures++; $display("FAIL late_ack busy=%b valid=%b instr=%h exp 0 0 0", busy, instr_valid, instr_out); end
  endtask

  task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
    int bad;
    halt = 1'b0;
    cyc();
    for (int i = 0; i < 14; i++) cyc();
    mem_ack = 1'b1; mem_data = 32'h00000013;
    cyc();
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0) begin failures++; $display("FAIL ack_on_limit valid=%b err=%b exp 1 0", instr_valid, fetch_err); end
    cyc();
    exec_done = 1'b1;
    cyc();
    exec_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (mem_req !== 1'b1 || fetch_err !== 1'b0) bad++;
      if (i < 14) cyc();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL timeout_window bad_cycles=%0d exp 0", bad); end
    cyc();
    checks++; if (fetch_err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 16'h0001) begin failures++; $display("FAIL timeout err=%b req=%b busy=%b addr=%h exp 1 0 0 0001", fetch_err, mem_req, busy, mem_addr); end
    cyc();
    checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky err=%b exp 1", fetch_err); end
    rst = 1'b0;
    cyc();
    rst = 1'b1; halt = 1'b1;
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL timeout_clear err=%b exp 0", fetch_err); end
`else
    halt = 1'b0;
    for (int i = 0; i < 40; i++) cyc();
    checks++; if (mem_req !== 1'b1 || fetch_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL fetch_waits req=%b err=%b busy=%b exp 1 0 1", mem_req, fetch_err, busy); end
    rst = 1'b0;
    cyc();
    rst = 1'b1; halt = 1'b1;
    checks++; if (mem_req !== 1'b0 || fetch_err !== 1'b0) begin failures++; $display("FAIL fetch_wait_reset req=%b err=%b exp 0 0", mem_req, fetch_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_fetch_issue();
    test_branch();
    test_nop();
    test_no_branch();
    test_wrap();
    test_halt();
    test_reset_mid_fetch();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
